// File: rtl/duart_tx_sched.sv
// duart_tx_sched
//   Round-robin scheduler sharing the debug UART (duart) APB slave among NREQ
//   byte-stream requesters. One byte is granted at a time; the scheduler polls
//   STATUS until the transmitter is not busy, then writes the byte to TXDATA.
//   It is the only APB master in front of duart_top.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   req_valid[NREQ]      requester i has a byte
//   req_data[8*NREQ]     byte i = req_data[8*i +: 8]
//   req_ready[NREQ]      one-hot single-cycle accept pulse
//   paddr/psel/penable/pwrite/pstrb/pprot/pwdata   APB request
//   prdata/pready/pslverr                          APB response
//   apbactive, busy      high whenever the FSM is not IDLE
//   err                  sticky PSLVERR / timeout flag, cleared only by reset
//
// Configuration
//   DUART_SCHED_TMO_EN   when defined, an ACCESS phase with pready low for
//                        TMO_CYC cycles is aborted (err set, byte dropped).
module duart_tx_sched #(
  parameter int          AW         = 12,
  parameter int          NREQ       = 3,
  parameter int unsigned TXDATA_OFS = 'h000,
  parameter int unsigned STATUS_OFS = 'h008,
  parameter int          POLL_GAP   = 4,
  parameter int          TMO_CYC    = 256
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [3:0]        pstrb,
  output logic [2:0]        pprot,
  output logic [31:0]       pwdata,
  output logic              apbactive,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SETUP, S_RD_ACCESS, S_GAP, S_WR_SETUP, S_WR_ACCESS
  } state_t;

  localparam int PW = $clog2(NREQ);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [7:0]    r_byte;
  logic [GW-1:0] r_gap;
  logic          r_err;
  // Low for the first cycle after reset so req_ready stays 0 while in reset.
  logic          r_live;

  logic          w_found;
  logic [PW-1:0] w_gnt;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_access;
  logic          w_tmo_hit;
  logic          w_unused_prdata;

  assign w_unused_prdata = ^prdata[31:1];
  assign w_access = (r_state == S_RD_ACCESS) || (r_state == S_WR_ACCESS);

  // First valid requester at or after r_ptr, wrapping modulo NREQ.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      w_idx = PW'(j);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == PW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

  assign req_ready = (r_live && (r_state == S_IDLE) && w_found) ?
                     (NREQ'(1) << w_gnt) : '0;

`ifdef DUART_SCHED_TMO_EN
  localparam int TW = $clog2(TMO_CYC) + 1;
  logic [TW-1:0] r_tmo;

  // r_tmo holds (cycles already spent in this ACCESS), so the abort lands on
  // the TMO_CYC-th cycle with pready still low.
  assign w_tmo_hit = w_access && !pready && (r_tmo == TW'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                             r_tmo <= '0;
    else if (!w_access || pready || w_tmo_hit) r_tmo <= '0;
    else                                     r_tmo <= r_tmo + 1'b1;
  end
`else
  localparam int unused_tmo_cyc = TMO_CYC;
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_byte  <= '0;
      r_gap   <= '0;
      r_err   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (r_live && w_found) begin
            r_byte  <= req_data[8*w_gnt +: 8];
            r_ptr   <= w_ptr_nxt;
            r_state <= S_RD_SETUP;
          end
        end
        S_RD_SETUP: r_state <= S_RD_ACCESS;
        S_RD_ACCESS: begin
          if (pready) begin
            if (pslverr) r_err <= 1'b1;
            // An errored status read is treated as "not busy".
            if (prdata[0] && !pslverr) begin
              if (POLL_GAP == 0) begin
                r_state <= S_RD_SETUP;
              end else begin
                r_gap   <= GW'(POLL_GAP - 1);
                r_state <= S_GAP;
              end
            end else begin
              r_state <= S_WR_SETUP;
            end
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap == '0) r_state <= S_RD_SETUP;
          else             r_gap   <= r_gap - 1'b1;
        end
        S_WR_SETUP: r_state <= S_WR_ACCESS;
        S_WR_ACCESS: begin
          if (pready) begin
            if (pslverr) r_err <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // APB outputs decode straight from the state register, so an async reset
  // drops psel/penable immediately.
  assign busy      = (r_state != S_IDLE);
  assign apbactive = busy;
  assign psel      = (r_state == S_RD_SETUP) || (r_state == S_RD_ACCESS) ||
                     (r_state == S_WR_SETUP) || (r_state == S_WR_ACCESS);
  assign penable   = w_access;
  assign pwrite    = (r_state == S_WR_SETUP) || (r_state == S_WR_ACCESS);
  assign pstrb     = pwrite ? 4'b0001 : 4'b0000;
  assign pprot     = 3'b000;
  assign paddr     = ((r_state == S_RD_SETUP) || (r_state == S_RD_ACCESS)) ? AW'(STATUS_OFS) :
                     pwrite ? AW'(TXDATA_OFS) : '0;
  assign pwdata    = {24'h0, r_byte};
  assign err       = r_err;

endmodule

// File: tb/tb_duart_tx_sched.sv
module tb_duart_tx_sched;
  localparam int NREQ = 3;
  localparam int AW   = 12;
  localparam int GAP  = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [AW-1:0]     paddr;
  logic              psel, penable, pwrite, apbactive, busy, err;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [31:0]       pwdata, prdata;
  logic              pready, pslverr;

  duart_tx_sched #(.AW(AW), .NREQ(NREQ), .TXDATA_OFS('h000), .STATUS_OFS('h008),
                   .POLL_GAP(GAP), .TMO_CYC(16)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstrb(pstrb), .pprot(pprot), .pwdata(pwdata),
    .apbactive(apbactive), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .err(err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  // APB slave model knobs
  int cfg_wait = 0;
  int busy_left = 0;
  bit slverr_wr = 1'b0;
  int wcnt = 0;
  // scoreboard / monitor state
  logic [7:0]    exp_q[$];
  logic [7:0]    e;
  int            n_rd = 0, n_wr = 0, rdy_pulses = 0, gaps_seen = 0, idle_run = 0;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_wdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (psel && penable && pready && !pwrite && busy_left > 0) busy_left <= busy_left - 1;
  end
  assign pready  = psel && penable && (wcnt >= cfg_wait);
  assign prdata  = {31'h0, (busy_left > 0)};
  assign pslverr = psel && penable && pwrite && slverr_wr;

  always @(negedge clk) begin
    if (resetn) begin
      if (req_ready != '0) begin
        rdy_pulses++;
        total++;
        if ($countones(req_ready) != 1) begin
          bad++; $display("FAIL ready_onehot got=%b want=one-hot", req_ready);
        end
      end
      if (busy && !psel) idle_run++;
      if (psel && !penable) begin
        if (idle_run > 0) begin
          gaps_seen++;
          total++;
          if (idle_run != GAP) begin
            bad++; $display("FAIL poll_gap got=%0d want=%0d", idle_run, GAP);
          end
        end
        idle_run  = 0;
        cap_addr  = paddr;
        cap_wdata = pwdata;
      end
      if (psel && penable) begin
        total++;
        if (paddr !== cap_addr || pwdata !== cap_wdata) begin
          bad++; $display("FAIL access_stable got=%h/%h want=%h/%h", paddr, pwdata, cap_addr, cap_wdata);
        end
        if (pready) begin
          if (pwrite) begin
            n_wr++;
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL write_unexpected got=%h want=none", pwdata);
            end else begin
              e = exp_q.pop_front();
              if (pwdata !== {24'h0, e} || paddr !== 12'h000 || pstrb !== 4'b0001) begin
                bad++; $display("FAIL write_data got=%h@%h s%b want=%h@000 s0001", pwdata, paddr, pstrb, e);
              end
            end
          end else begin
            n_rd++;
            total++;
            if (paddr !== 12'h008 || pstrb !== 4'b0000) begin
              bad++; $display("FAIL read_addr got=%h s%b want=008 s0000", paddr, pstrb);
            end
          end
        end
      end
      if (!busy) idle_run = 0;
    end
  end

  task automatic wait_ready(output logic [NREQ-1:0] seen, output bit ok);
    ok = 1'b0; seen = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin seen = req_ready; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  // Offer one byte on requester idx, expect it as the next TX write if push.
  task automatic send_one(input int idx, input logic [7:0] d, input bit push,
                          output logic [NREQ-1:0] seen, output bit ok);
    @(posedge clk); #1;
    req_data[8*idx +: 8] = d;
    req_valid = NREQ'(1) << idx;
    if (push) exp_q.push_back(d);
    wait_ready(seen, ok);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_reset();
    req_valid = '1;
    req_data  = 24'h123456;
    #12;
    total++;
    if ({req_ready, paddr, psel, penable, pwrite, pstrb, pprot, pwdata, apbactive, busy, err} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b%h%b%b%b want=0", req_ready, paddr, psel, busy, err);
    end
    req_valid = '0;
    @(posedge clk); #1 resetn = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      bad++; $display("FAIL reset_idle got=%b/%b want=0/0", busy, req_ready);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] seen; bit ok; int c0, r0, w0, p0;
    r0 = n_rd; w0 = n_wr; p0 = rdy_pulses;
    @(posedge clk); #1;
    req_data = 24'h000041; req_valid = 3'b001; exp_q.push_back(8'h41);
    wait_ready(seen, ok);
    c0 = cyc;
    total++;
    if (!ok || seen !== 3'b001) begin bad++; $display("FAIL single_ready got=%b want=001", seen); end
    @(posedge clk); #1 req_valid = '0;
    wait_idle(100, ok);
    total++;
    if (!ok || cyc - c0 != 5) begin bad++; $display("FAIL single_cycles got=%0d want=5", cyc - c0); end
    total++;
    if (n_rd - r0 != 1 || n_wr - w0 != 1) begin
      bad++; $display("FAIL single_xfers got=%0d/%0d want=1/1", n_rd - r0, n_wr - w0);
    end
    total++;
    if (rdy_pulses - p0 != 1) begin bad++; $display("FAIL single_pulse got=%0d want=1", rdy_pulses - p0); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL single_drain got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_busy_poll();
    logic [NREQ-1:0] seen; bit ok; int r0, w0, g0;
    r0 = n_rd; w0 = n_wr; g0 = gaps_seen;
    busy_left = 3;
    send_one(2, 8'h55, 1'b1, seen, ok);
    total++;
    if (!ok || seen !== 3'b100) begin bad++; $display("FAIL poll_ready got=%b want=100", seen); end
    wait_idle(200, ok);
    total++;
    if (!ok || n_rd - r0 != 4 || n_wr - w0 != 1) begin
      bad++; $display("FAIL poll_xfers got=%0d/%0d want=4/1", n_rd - r0, n_wr - w0);
    end
    total++;
    if (gaps_seen - g0 != 3) begin bad++; $display("FAIL poll_gaps got=%0d want=3", gaps_seen - g0); end
  endtask

  task automatic test_rr();
    logic [NREQ-1:0] seen; bit ok;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h30);
    end
    @(posedge clk); #1;
    req_data = 24'h302010; req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ready(seen, ok);
      total++;
      if (!ok || seen !== (NREQ'(1) << (k % 3))) begin
        bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, seen, NREQ'(1) << (k % 3));
      end
      @(posedge clk); #1;
      if (k == 5) req_valid = '0;
    end
    wait_idle(100, ok);
    total++;
    if (!ok || exp_q.size() != 0) begin bad++; $display("FAIL rr_drain got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_wait_states();
    logic [NREQ-1:0] seen; bit ok;
    cfg_wait = 5;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    @(posedge clk); #1;
    req_data = 24'h5AA500; req_valid = 3'b110;
    for (int k = 0; k < 2; k++) begin
      wait_ready(seen, ok);
      total++;
      if (!ok || seen !== (NREQ'(1) << (k + 1))) begin
        bad++; $display("FAIL ws_grant%0d got=%b want=%b", k, seen, NREQ'(1) << (k + 1));
      end
      @(posedge clk); #1;
      if (k == 1) req_valid = '0;
    end
    wait_idle(200, ok);
    total++;
    if (!ok || exp_q.size() != 0) begin bad++; $display("FAIL ws_drain got=%0d want=0", exp_q.size()); end
    cfg_wait = 0;
  endtask

  task automatic test_slverr();
    logic [NREQ-1:0] seen; bit ok;
    slverr_wr = 1'b1;
    send_one(0, 8'h77, 1'b1, seen, ok);
    wait_idle(100, ok);
    slverr_wr = 1'b0;
    total++;
    if (!ok || err !== 1'b1) begin bad++; $display("FAIL slverr_set got=%b want=1", err); end
    send_one(0, 8'h78, 1'b1, seen, ok);
    wait_idle(100, ok);
    total++;
    if (!ok || err !== 1'b1 || exp_q.size() != 0) begin
      bad++; $display("FAIL slverr_sticky got=%b/%0d want=1/0", err, exp_q.size());
    end
    // reset in the middle of a stalled ACCESS
    cfg_wait = 5;
    send_one(1, 8'h99, 1'b1, seen, ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (psel && penable) begin ok = 1'b1; break; end
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (!ok || {psel, penable, busy, apbactive, err, pwdata} !== '0) begin
      bad++; $display("FAIL reset_mid got=%b%b%b%b%b %h want=0", psel, penable, busy, apbactive, err, pwdata);
    end
    exp_q.delete();
    cfg_wait = 0;
    @(posedge clk); #1 resetn = 1'b1;
    send_one(0, 8'h42, 1'b1, seen, ok);
    wait_idle(100, ok);
    total++;
    if (!ok || err !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL after_reset got=%b/%0d want=0/0", err, exp_q.size());
    end
  endtask

`ifdef DUART_SCHED_TMO_EN
  task automatic test_tmo();
    logic [NREQ-1:0] seen; bit ok; int a, w0;
    w0 = n_wr;
    cfg_wait = 1000;
    send_one(0, 8'hEE, 1'b0, seen, ok);
    ok = 1'b0; a = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (psel && penable) begin ok = 1'b1; a = cyc; break; end
    end
    wait_idle(100, ok);
    total++;
    if (!ok || cyc - a != 16) begin bad++; $display("FAIL tmo_cycles got=%0d want=16", cyc - a); end
    total++;
    if (err !== 1'b1 || psel !== 1'b0 || n_wr != w0) begin
      bad++; $display("FAIL tmo_abort got=%b/%b/%0d want=1/0/0", err, psel, n_wr - w0);
    end
    cfg_wait = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_busy_poll();
    test_rr();
    test_wait_states();
    test_slverr();
`ifdef DUART_SCHED_TMO_EN
    test_tmo();
`endif
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL final_drain got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
